carry_lookahead_adder: RTL and testbench

CARRY_LOOKAHEAD_ADDER -- requirements
Module: carry_lookahead_adder

---
 rtl/carry_lookahead_adder_pkg.sv | 10 +
 rtl/carry_lookahead_adder_block.sv | 28 ++
 rtl/carry_lookahead_adder.sv | 105 ++++++++++
 tb/tb_carry_lookahead_adder.sv | 139 +++++++++++++
 4 files changed

// File: rtl/carry_lookahead_adder_pkg.sv
// Shared helpers for the carry-lookahead adder.
//   ceil_div : integer ceiling division, used to size the number of
//              lookahead blocks for an arbitrary operand width.
package carry_lookahead_adder_pkg;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/carry_lookahead_adder_block.sv
// cla_block_4 -- first-level 4-bit carry-lookahead block.
// Ports:
//   g[3:0], p[3:0] : per-bit generate / propagate
//   c_in           : carry into bit 0 of the block
//   c[3:0]         : carry into each bit of the block (c[0] = c_in)
//   G, P           : group generate / group propagate for the second level
// Every carry is a flat sum of products of g, p and c_in (two-level logic),
// so no carry waits on a lower bit's carry.
module cla_block_4 (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       c_in,
    output logic [3:0] c,
    output logic       G,
    output logic       P
);

    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);

    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    assign P = &p;

endmodule

// File: rtl/carry_lookahead_adder.sv
// carry_lookahead_adder -- registered two-level carry-lookahead adder.
// Parameter N : operand width (any value >= 1).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears Sum and Cout
//   A, B  : unsigned N-bit addends
//   Cin   : carry-in
//   Sum   : registered sum, valid one cycle after the operands
//   Cout  : registered carry-out of bit N-1
// Bits are grouped in 4-bit cla_block_4 instances; a second lookahead level
// over the group G/P produces each block's carry-in. Unused bits of a
// partial top block have g = p = 0.
module carry_lookahead_adder
    import carry_lookahead_adder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    localparam int BLOCK = 4;
    localparam int NB    = ceil_div(N, BLOCK);
    localparam int W     = NB * BLOCK;

    logic [W-1:0] a_pad, b_pad;
    logic [W-1:0] g, p;
    logic [W-1:0] c_all;      // carry into each (padded) bit position
    logic [NB:0]  blk_c;      // carry into each block; blk_c[NB] = out of top
    logic [NB-1:0] blk_g, blk_p;
    logic [N-1:0] sum_d;
    logic         cout_d;

    // NOTE: every variable assigned in always_comb gets a full default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        a_pad        = '0;
        b_pad        = '0;
        a_pad[N-1:0] = A;
        b_pad[N-1:0] = B;
    end

    assign g = a_pad & b_pad;
    assign p = a_pad ^ b_pad;

    for (genvar b = 0; b < NB; b++) begin : g_blk
        cla_block_4 u_blk (
            .g    (g[BLOCK*b +: BLOCK]),
            .p    (p[BLOCK*b +: BLOCK]),
            .c_in (blk_c[b]),
            .c    (c_all[BLOCK*b +: BLOCK]),
            .G    (blk_g[b]),
            .P    (blk_p[b])
        );
    end

    // Second level: blk_c[j] = OR_k (G[k] & P[k+1..j-1]) | (Cin & P[0..j-1]).
    // The loops unroll into one flat sum of products per block carry.
    logic acc, prod;
    always_comb begin
        blk_c    = '0;
        acc      = 1'b0;
        prod     = 1'b0;
        blk_c[0] = Cin;
        for (int j = 1; j <= NB; j++) begin
            acc = 1'b0;
            for (int k = 0; k < j; k++) begin
                prod = blk_g[k];
                for (int m = k + 1; m < j; m++) prod = prod & blk_p[m];
                acc = acc | prod;
            end
            prod = Cin;
            for (int m = 0; m < j; m++) prod = prod & blk_p[m];
            blk_c[j] = acc | prod;
        end
    end

    assign sum_d = p[N-1:0] ^ c_all[N-1:0];

    // In a partial top block the zeroed pad bits kill the group generate, so
    // the carry-out is taken from the internal carry into bit N instead.
    if (N % BLOCK == 0) begin : g_cout_full
        assign cout_d = blk_c[NB];
    end else begin : g_cout_part
        assign cout_d = c_all[N];
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum  <= '0;
            Cout <= 1'b0;
        end else begin
            Sum  <= sum_d;
            Cout <= cout_d;
        end
    end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Self-checking bench for carry_lookahead_adder at N=4 and N=10.
// A reference model (plain integer addition, zero while in reset) is
// compared every cycle; directed vectors pin hand-computed results.
module tb_carry_lookahead_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a4, b4, sum4;
    logic       cin4, cout4;
    logic [9:0] a10, b10, sum10;
    logic       cin10, cout10;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    carry_lookahead_adder #(.N(4)) dut4 (
        .clk (clk), .rst_n (rst_n),
        .A (a4), .B (b4), .Cin (cin4),
        .Sum (sum4), .Cout (cout4)
    );

    carry_lookahead_adder #(.N(10)) dut10 (
        .clk (clk), .rst_n (rst_n),
        .A (a10), .B (b10), .Cin (cin10),
        .Sum (sum10), .Cout (cout10)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: the result registered at an edge is A+B+Cin of the
    // operands present at that edge, or zero when reset is held.
    logic [4:0]  exp4;
    logic [10:0] exp10;
    always @(posedge clk) begin
        if (rst_n) begin
            exp4  = 5'(a4) + 5'(b4) + 5'(cin4);
            exp10 = 11'(a10) + 11'(b10) + 11'(cin10);
        end else begin
            exp4  = '0;
            exp10 = '0;
        end
        #1;
        check("model_n4",  32'({cout4, sum4}),   32'(exp4));
        check("model_n10", 32'({cout10, sum10}), 32'(exp10));
    end

    task automatic apply(input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [9:0] x,
                         input logic [9:0] y, input logic cy);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = c;
        a10 = x; b10 = y; cin10 = cy;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        a4 = 4'd9; b4 = 4'd9; cin4 = 1'b1;
        a10 = 10'd7; b10 = 10'd7; cin10 = 1'b0;
        #3;
        check("reset_sum4",  32'(sum4),  32'h0);
        check("reset_cout4", 32'(cout4), 32'h0);
        repeat (2) @(negedge clk);
        check("reset_held_sum10", 32'({cout10, sum10}), 32'h0);

        // Release together with the first operands: that edge loads them.
        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'b1111; b4 = 4'b0000; cin4 = 1'b1;
        a10 = 10'h3FF; b10 = 10'h001; cin10 = 1'b0;
        @(negedge clk);
        check("prop_chain_sum4",  32'(sum4),   32'h0);
        check("prop_chain_cout4", 32'(cout4),  32'h1);
        check("n10_wrap_sum",     32'(sum10),  32'h000);
        check("n10_wrap_cout",    32'(cout10), 32'h1);

        apply(4'b1111, 4'b1111, 1'b1, 10'h3FF, 10'h3FF, 1'b1);
        @(negedge clk);
        check("all_ones_n4",  32'({cout4, sum4}),   32'h1F);
        check("all_ones_n10", 32'({cout10, sum10}), 32'h7FF);

        apply(4'b0101, 4'b0011, 1'b0, 10'h155, 10'h0AB, 1'b0);
        @(negedge clk);
        check("mix_sum4",  32'(sum4),  32'h8);
        check("mix_cout4", 32'(cout4), 32'h0);
        check("mix_n10",   32'({cout10, sum10}), 32'h200);

        // Asynchronous reset between edges while outputs hold 1000/0.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sum4",  32'(sum4),  32'h0);
        check("async_rst_cout4", 32'(cout4), 32'h0);
        check("async_rst_n10",   32'({cout10, sum10}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'd3; b4 = 4'd4; cin4 = 1'b1;
        a10 = 10'd0; b10 = 10'd0; cin10 = 1'b0;
        @(negedge clk);
        check("post_rst_sum4",  32'(sum4),  32'h8);
        check("post_rst_cout4", 32'(cout4), 32'h0);

        apply(4'd0, 4'd0, 1'b0, 10'd0, 10'd0, 1'b0);
        @(negedge clk);
        check("zero_n4",  32'({cout4, sum4}),   32'h0);
        check("zero_n10", 32'({cout10, sum10}), 32'h0);

        // Exhaustive N=4 back-to-back, with random N=10 operands alongside.
        for (int i = 0; i < 512; i++)
            apply(4'(i), 4'(i >> 4), 1'(i >> 8),
                  10'($urandom), 10'($urandom), 1'($urandom));
        // Further random N=10 vectors to reach 1000.
        for (int i = 0; i < 488; i++)
            apply(4'($urandom), 4'($urandom), 1'($urandom),
                  10'($urandom), 10'($urandom), 1'($urandom));

        apply(4'd0, 4'd0, 1'b0, 10'd0, 10'd0, 1'b0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
